pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter register and instruction-fetch sequencer that consumes the selected next-PC produced by the jump-register select mux. It holds the architectural PC, issues one-outstanding fetch requests to instruction memory, buffers returned instructions toward decode, and handles redirects (jump, branch, jr) and decode stalls. It sits between the next-PC select chain and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `PC_W`, 32: PC and instruction width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `redirect` in 1: control transfer taken this cycle.
- `next_pc_in` in PC_W: target PC from the jump-register select mux, valid when `redirect`=1.
- `stall` in 1: decode cannot accept `if_instr` this cycle.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out PC_W: fetch address.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in PC_W: instruction word.
- `if_valid` out 1: `if_instr`/`if_pc` hold a live instruction.
- `if_instr` out PC_W: fetched instruction.
- `if_pc` out PC_W: address of `if_instr`.
- `if_pc_plus4` out PC_W: `if_pc`+4, for link and branch arithmetic.
- `misalign_trap` out 1: misaligned redirect target (see Configuration).

## Operation
- One clock `clk`; `rst` is synchronous and active-high.
- FSM states: REQ (drive request), WAIT (one request outstanding), HOLD (output slot and skid full, fetch paused).
- Reset: `pc`=RESET_PC, state REQ, `kill`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0, `imem_req`=0 during the reset cycle, `misalign_trap`=0, skid empty.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`: latch `fetch_pc`=`pc`, `pc`<=`pc`+4 (32-bit wrap, 0xFFFF_FFFC -> 0), go to WAIT.
- WAIT: `imem_req`=0 unless `imem_rvalid` arrives and issuing is allowed, in which case the next request is driven in the same cycle, giving back-to-back fetch.
- Issuing is allowed only when the skid is empty and (`if_valid`=0 or `stall`=0).
- Response, `kill`=0: loads the output slot if it is free or being consumed; otherwise loads the skid. Skid full -> HOLD.
- Response, `kill`=1: discarded, `kill` cleared, REQ.
- HOLD: no request; when `stall` drops, skid moves to the output slot, then REQ.
- `stall`=1 with `if_valid`=1: all `if_*` outputs held stable.
- Redirect, any state: `pc`<=`next_pc_in`; output slot and skid flushed (`if_valid`<=0). If a request is outstanding, or accepted this same cycle, `kill`<=1. Next state REQ, or WAIT if a kill is pending.
- Priority: `rst` > `redirect` > `stall` > normal flow.

## Timing
- First `imem_req` in the first cycle after `rst` deasserts, with `imem_addr`=RESET_PC.
- Zero-wait memory (ready=1, rvalid one cycle later): `if_valid` rises 2 cycles after reset release; throughput is 1 instruction per cycle.
- Redirect in cycle N: `imem_addr`=target by N+1 when nothing is outstanding; otherwise in the cycle the killed response returns.
- `if_valid` drops in the cycle after a redirect.
- `misalign_trap` is a one-cycle pulse in the cycle after the offending redirect.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: a redirect with `next_pc_in[1:0]`!=0 pulses `misalign_trap`, leaves `pc` unchanged, and performs no flush. Fetch continues sequentially; trap handling is the control unit's job.
- Undefined: `next_pc_in[1:0]` is forced to 00 and `misalign_trap` is tied 0. The port stays present.

## Structure
- `pc_fetch_pkg`: state enum (REQ, WAIT, HOLD), `PC_INC`=4, default `RESET_PC_DEF`.
- Sub-module `fetch_skid_buf`: one-entry instruction/PC buffer with load, drain and flush controls.

## Test plan
- Reset release, ready=1, rvalid after 1 cycle, rdata=addr^A5A5 -> addresses 0, 4, 8 issued on consecutive cycles; `if_pc` 0, 4, 8 with matching `if_instr`.
- `stall` high for 3 cycles after `if_pc`=8 -> outputs frozen, at most one response skidded, no further request; resumes with `if_pc`=0xC.
- Redirect to 0x100 while a request is in WAIT -> stale response dropped; next `if_pc`=0x100 with no 0x10 delivered.
- Redirect and `stall` together -> flush wins; `if_valid`=0 next cycle.
- PC 0xFFFF_FFFC fetched -> next address 0x0000_0000.
- With `PC_MISALIGN_TRAP_EN`, redirect to 0x102 -> `misalign_trap` pulses once, fetch continues sequentially; without the macro, fetch goes to 0x100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer.
// Holds the fetch FSM state encoding, the sequential PC increment and
// the default reset PC.
package pc_fetch_pkg;

  // REQ: drive a request. WAIT: one request outstanding.
  // HOLD: output slot and skid both full, fetch paused.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC buffer that catches a fetch response arriving
// while the IF/ID output slot is full and stalled.
// Flush and drain both empty the entry; flush wins over load.
module fetch_skid_buf
  import pc_fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         flush_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_i,
  output logic         valid_o,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o
);

  logic         valid_q;
  logic [W-1:0] instr_q;
  logic [W-1:0] pc_q;

  // Single entry: emptied by flush/drain, filled by load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i || drain_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Keeps one request outstanding to instruction memory, buffers responses
// into the IF/ID output slot (plus a one-entry skid) and handles redirects
// and decode stalls. Responses belonging to a request issued before a
// redirect are dropped through the kill flag.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps
// instead of being aligned down).
//
// Memory handshake: a request transfers in a cycle where imem_req and
// imem_ready are both high; imem_addr is stable while imem_req is held.
// Each accepted request returns exactly one imem_rvalid pulse later.
// Decode consumes the slot in any cycle where if_valid=1 and stall=0.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [PC_W-1:0] next_pc_in,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            if_valid,
  output logic [PC_W-1:0] if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_pc_plus4,
  output logic            misalign_trap,
  output logic [1:0]      dbg_state
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q, kill_d;

  logic            if_valid_q;
  logic [PC_W-1:0] if_instr_q, if_pc_q, if_pc_plus4_q;

  logic            skid_valid;
  logic [PC_W-1:0] skid_instr, skid_pc;

  logic            req, accept, outstanding, issue_ok;
  logic            slot_load, skid_load, skid_drain, flush;
  logic            redirect_eff;
  logic [PC_W-1:0] target;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign;
  logic trap_q;

  // A misaligned target is not taken: no PC change, no flush, just a trap pulse.
  assign misalign     = |next_pc_in[1:0];
  assign redirect_eff = redirect && !misalign;
  assign target       = next_pc_in;

  // One-cycle trap pulse following the offending redirect.
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= redirect && misalign;
  end

  assign misalign_trap = trap_q;
`else
  assign redirect_eff  = redirect;
  assign target        = next_pc_in & ~PC_W'(3);
  assign misalign_trap = 1'b0;
`endif

  // A new request may go out only if its response has somewhere to land.
  assign issue_ok = !skid_valid && (!if_valid_q || !stall);

  // Fetch FSM next-state, request generation and datapath controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    req        = 1'b0;
    slot_load  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    flush      = 1'b0;
    case (state_q)
      REQ: req = 1'b1;
      WAIT: begin
        if (imem_rvalid) begin
          // Back-to-back issue when the response is usable or was killed.
          req     = issue_ok;
          state_d = REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (issue_ok) begin
            slot_load = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          skid_drain = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    accept = req && imem_ready;
    if (accept) begin
      fetch_pc_d = pc_q;
      pc_d       = pc_q + INC;
      state_d    = WAIT;
    end

    // Anything still in flight after this edge must be dropped on redirect.
    outstanding = accept || (state_q == WAIT && !imem_rvalid);
    if (redirect_eff) begin
      pc_d       = target;
      kill_d     = outstanding;
      state_d    = outstanding ? WAIT : REQ;
      flush      = 1'b1;
      slot_load  = 1'b0;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
    end
  end

  // FSM state, architectural PC, in-flight fetch address and kill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
    end
  end

  // IF/ID output slot: held while stalled, refilled from memory or the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else if (flush) begin
      if_valid_q <= 1'b0;
    end else if (slot_load) begin
      if_valid_q    <= 1'b1;
      if_instr_q    <= imem_rdata;
      if_pc_q       <= fetch_pc_q;
      if_pc_plus4_q <= fetch_pc_q + INC;
    end else if (skid_drain) begin
      if_valid_q    <= 1'b1;
      if_instr_q    <= skid_instr;
      if_pc_q       <= skid_pc;
      if_pc_plus4_q <= skid_pc + INC;
    end else if (!stall) begin
      if_valid_q <= 1'b0;
    end
  end

  fetch_skid_buf #(.W(PC_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (flush),
    .instr_i (imem_rdata),
    .pc_i    (fetch_pc_q),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign imem_req    = req && !rst;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign dbg_state   = state_q;

endmodule
